adder_share_ctrl: RTL and testbench

- Sequencer/arbiter that time-shares one 8-bit ripple adder (adder_zero, 9-bit sum with carry-out) between two requesters.
- Accepts an operand pair per handshake, drives the shared adder's inputs from registers and waits a fixed settle latency.
- Captures the 9-bit sum and returns it to the granted requester with a one-cycle response pulse.
- Sits between the requesting datapath blocks and the single adder_zero instance, which stays outside this block.

---
 rtl/adder_share_pkg.sv | 15 +
 rtl/adder_share_ctrl.sv | 106 ++++++++++
 tb/tb_adder_share_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and constants for the adder sharing controller
package adder_share_pkg;

    localparam int OP_W  = 8;
    localparam int SUM_W = 9;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - time-shares one external adder between two requesters
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int ADD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    input  logic [OP_W-1:0]  req0_a,
    input  logic [OP_W-1:0]  req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OP_W-1:0]  req1_a,
    input  logic [OP_W-1:0]  req1_b,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic [SUM_W-1:0] resp0_sum,
    output logic             resp1_valid,
    output logic [SUM_W-1:0] resp1_sum,
    output logic [OP_W-1:0]  adder_in0,
    output logic [OP_W-1:0]  adder_in1,
    input  logic [SUM_W-1:0] adder_out,
    output logic             busy,
    output logic             grant_id
);

    localparam logic [3:0] LAT_M1 = 4'(ADD_LATENCY - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] count;
    logic       last_grant;
    logic       accept;
    logic       accept_id;
    logic       done;

    // Round-robin: on contention the requester that did not win last time goes first.
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant == REQ1)) begin
                    req0_ready = 1'b1;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                end
                if (req0_ready || req1_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept    = req0_ready | req1_ready;
    assign accept_id = req1_ready;
    assign done      = (state == WAIT) && (count == 4'd0);
    assign busy      = (state == WAIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            count       <= 4'd0;
            last_grant  <= REQ1;
            grant_id    <= REQ0;
            adder_in0   <= '0;
            adder_in1   <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_sum   <= '0;
            resp1_sum   <= '0;
        end else begin
            state       <= next_state;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            if (accept) begin
                adder_in0  <= accept_id ? req1_a : req0_a;
                adder_in1  <= accept_id ? req1_b : req0_b;
                grant_id   <= accept_id;
                last_grant <= accept_id;
                count      <= LAT_M1;
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            // Result returns to whoever owns the operation in flight.
            if (done) begin
                if (grant_id == REQ1) begin
                    resp1_valid <= 1'b1;
                    resp1_sum   <= adder_out;
                end else begin
                    resp0_valid <= 1'b1;
                    resp0_sum   <= adder_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - self-checking bench for adder_share_ctrl
module tb_adder_share_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic       resp0_valid, resp1_valid;
    logic [8:0] resp0_sum, resp1_sum;
    logic [7:0] adder_in0, adder_in1;
    logic [8:0] adder_out;
    logic [8:0] adder_pipe;
    logic       busy, grant_id;

    adder_share_ctrl #(.ADD_LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_sum(resp0_sum),
        .resp1_valid(resp1_valid), .resp1_sum(resp1_sum),
        .adder_in0(adder_in0), .adder_in1(adder_in1), .adder_out(adder_out),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared adder: result settles one edge after its inputs change.
    always @(posedge clk) adder_pipe <= {1'b0, adder_in0} + {1'b0, adder_in1};
    assign adder_out = adder_pipe;

    int total = 0;
    int bad   = 0;

    // reference model state
    int         cyc, next_free, due;
    bit         last_g, pend, p_req, m_grant;
    logic [8:0] p_sum, m_sum0, m_sum1;
    logic [7:0] m_in0, m_in1;
    bit         obs_rv0, obs_rv1;
    logic [8:0] obs_s0, obs_s1;

    typedef struct {
        bit         req;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; next_free = 0; due = 0;
        last_g = 1'b1; pend = 1'b0; p_req = 1'b0; m_grant = 1'b0;
        p_sum = '0; m_sum0 = '0; m_sum1 = '0; m_in0 = '0; m_in1 = '0;
    endtask

    // Drives one cycle from a negedge, checks everything against the model, advances to next negedge.
    task automatic step(input bit v0, input logic [7:0] a0, input logic [7:0] b0,
                        input bit v1, input logic [7:0] a1, input logic [7:0] b1,
                        output bit acc0, output bit acc1);
        bit idle, e0, e1, rv;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        idle = (cyc >= next_free);
        e0 = idle && v0 && (!v1 || last_g == 1'b1);
        e1 = idle && v1 && (!v0 || last_g == 1'b0);
        rv = pend && (due == cyc);
        if (rv) begin
            if (p_req) m_sum1 = p_sum; else m_sum0 = p_sum;
            pend = 1'b0;
        end
        obs_rv0 = resp0_valid; obs_rv1 = resp1_valid;
        obs_s0 = resp0_sum; obs_s1 = resp1_sum;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("one_ready", req0_ready & req1_ready, 0);
        chk("busy", busy, !idle);
        chk("grant_id", grant_id, m_grant);
        chk("resp0_valid", resp0_valid, rv && !p_req);
        chk("resp1_valid", resp1_valid, rv && p_req);
        chk("resp0_sum", resp0_sum, m_sum0);
        chk("resp1_sum", resp1_sum, m_sum1);
        chk("adder_in0", adder_in0, m_in0);
        chk("adder_in1", adder_in1, m_in1);
        if (e0 || e1) begin
            p_req = e1;
            m_in0 = e1 ? a1 : a0;
            m_in1 = e1 ? b1 : b0;
            p_sum = 9'(m_in0) + 9'(m_in1);
            pend = 1'b1;
            due = cyc + LAT + 1;
            next_free = due;
            last_g = e1;
            m_grant = e1;
        end
        acc0 = e0; acc1 = e1;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_step();
        bit x0, x1;
        step(0, 8'hEE, 8'hDD, 0, 8'hCC, 8'hBB, x0, x1);
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        bit a0, a1;
        int g[$];

        tbl[0] = '{0, 8'd200, 8'd100, 9'h12C};
        tbl[1] = '{0, 8'd255, 8'd255, 9'h1FE};
        tbl[2] = '{1, 8'd10,  8'd20,  9'd30};
        tbl[3] = '{1, 8'd0,   8'd0,   9'd0};
        tbl[4] = '{0, 8'd1,   8'd2,   9'd3};
        tbl[5] = '{1, 8'd3,   8'd4,   9'd7};
        tbl[6] = '{1, 8'd255, 8'd1,   9'h100};

        model_reset();
        do_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_resp", {resp0_valid, resp1_valid, resp0_sum, resp1_sum}, 0);
        chk("rst_adder_in", {adder_in0, adder_in1}, 0);

        // single transactions from idle, response expected three cycles after accept
        foreach (tbl[i]) begin
            step(!tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].req, tbl[i].a, tbl[i].b, a0, a1);
            chk("tbl_accept", tbl[i].req ? a1 : a0, 1);
            idle_step();
            idle_step();
            idle_step();
            chk("tbl_resp_valid", tbl[i].req ? obs_rv1 : obs_rv0, 1);
            chk("tbl_resp_other", tbl[i].req ? obs_rv0 : obs_rv1, 0);
            chk("tbl_sum", tbl[i].req ? obs_s1 : obs_s0, tbl[i].sum);
        end

        // contention: grants alternate starting with requester 0 after reset
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, 8'd1, 8'd2, 1, 8'd3, 8'd4, a0, a1);
            if (a0 || a1) g.push_back(a1 ? 1 : 0);
        end
        idle_step(); idle_step(); idle_step();
        chk("rr_count", g.size(), 3);
        if (g.size() >= 3) begin
            chk("rr_g0", g[0], 0);
            chk("rr_g1", g[1], 1);
            chk("rr_g2", g[2], 0);
        end

        // req1 back-to-back: second accept coincides with first response
        step(0, 0, 0, 1, 8'd10, 8'd20, a0, a1);
        idle_step(); idle_step();
        step(0, 0, 0, 1, 8'd0, 8'd0, a0, a1);
        chk("b2b_accept", a1, 1);
        chk("b2b_resp_same_cycle", obs_rv1, 1);
        chk("b2b_sum1", obs_s1, 30);
        idle_step(); idle_step(); idle_step();
        chk("b2b_sum2", obs_s1, 0);

        // operands change while waiting; result must reflect the accept-edge operands
        step(1, 8'd7, 8'd9, 0, 0, 0, a0, a1);
        step(0, 8'd100, 8'd100, 0, 8'd50, 8'd50, a0, a1);
        step(0, 8'd200, 8'd1, 0, 8'd60, 8'd70, a0, a1);
        idle_step();
        chk("hold_sum", obs_s0, 16);

        // reset in the middle of WAIT
        step(0, 0, 0, 1, 8'd40, 8'd2, a0, a1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out", {resp0_valid, resp1_valid, resp0_sum, resp1_sum, grant_id}, 0);
        chk("midrst_adder_in", {adder_in0, adder_in1}, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("midrst_no_pulse", {resp0_valid, resp1_valid}, 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        step(1, 8'd5, 8'd6, 1, 8'd7, 8'd8, a0, a1);
        chk("postrst_req0_wins", {a0, a1}, 2'b10);
        repeat (4) idle_step();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 1), 8'($urandom), 8'($urandom), a0, a1);
        end
        repeat (4) idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
